// File: rtl/bcd_to_bin_iter.sv
// bcd_to_bin_iter: iterative packed-BCD to binary converter, one digit per clock.
// Ports: clk, rst (sync, active-high); bcdIn/inValid/inReady operand handshake;
//        binOut/errOut/outValid/outReady result handshake (errOut flags a digit > 9).
module bcd_to_bin_iter #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] bcdIn,
    input  logic                inValid,
    output logic                inReady,
    output logic [BIN_W-1:0]    binOut,
    output logic                errOut,
    output logic                outValid,
    input  logic                outReady
);
    localparam int CW = $clog2(DIGITS + 1);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t              state;
    logic [4*DIGITS-1:0] sr;
    logic [BIN_W-1:0]    acc;
    logic [CW-1:0]       cnt;
    logic                err;
    logic [3:0]          d;
    assign d = sr[4*DIGITS-1 -: 4];
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
            binOut   <= '0;
            errOut   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (inValid && inReady) begin
                    sr      <= bcdIn;
                    acc     <= '0;
                    cnt     <= '0;
                    err     <= 1'b0;
                    inReady <= 1'b0;
                    state   <= CONV;
                end
                CONV: begin
                    acc <= (acc << 3) + (acc << 1) + BIN_W'(d);
                    sr  <= sr << 4;
                    err <= err | (d > 4'd9);
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIGITS - 1)) state <= DONE;
                end
                // First DONE cycle loads the output registers; the result is
                // presented (outValid=1) from the following cycle until taken.
                DONE: if (!outValid) begin
                    outValid <= 1'b1;
                    errOut   <= err;
                    binOut   <= err ? '0 : acc;
                end else if (outReady) begin
                    outValid <= 1'b0;
                    inReady  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_iter.sv
module tb_bcd_to_bin_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        in_valid, in_ready, out_valid, out_ready, err_out;
    logic [13:0] bin_out;
    logic [7:0]  bcd2;
    logic        iv2, ir2, ov2, or2, eo2;
    logic [6:0]  bo2;
    int          n_chk = 0;
    int          n_fail = 0;

    bcd_to_bin_iter #(.DIGITS(4), .BIN_W(14)) u_dut (
        .clk(clk), .rst(rst), .bcdIn(bcd_in), .inValid(in_valid), .inReady(in_ready),
        .binOut(bin_out), .errOut(err_out), .outValid(out_valid), .outReady(out_ready)
    );

    bcd_to_bin_iter #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk(clk), .rst(rst), .bcdIn(bcd2), .inValid(iv2), .inReady(ir2),
        .binOut(bo2), .errOut(eo2), .outValid(ov2), .outReady(or2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] bcd, output int lat);
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        bcd_in   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] bcd, input int exp_bin, input bit exp_err);
        int lat;
        issue(bcd, lat);
        check({tag, "_lat"}, lat, 5);
        check({tag, "_bin"}, bin_out, exp_bin);
        check({tag, "_err"}, err_out, exp_err);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_after_hs"}, out_valid, 0);
        check({tag, "_ir_after_hs"}, in_ready, 1);
    endtask

    task automatic run2(input string tag, input logic [7:0] bcd, input int exp_bin, input bit exp_err);
        int lat;
        for (int i = 0; i < 20 && !ir2; i++) tick();
        bcd2 = bcd;
        iv2  = 1'b1;
        tick();
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_bin"}, bo2, exp_bin);
        check({tag, "_err"}, eo2, exp_err);
        or2 = 1'b1;
        tick();
        or2 = 1'b0;
        check({tag, "_ov_after_hs"}, ov2, 0);
    endtask

    initial begin
        int lat, a1, a2, h1, h2;
        logic pr, pv, seen;
        logic [13:0] pb, r1, r2;
        rst = 1'b1; in_valid = 1'b1; bcd_in = 16'h1234; out_ready = 1'b0;
        iv2 = 1'b1; bcd2 = 8'h12; or2 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_bin_out", bin_out, 0);
        check("rst_err_out", err_out, 0);
        check("rst2_in_ready", ir2, 1);
        rst = 1'b0; in_valid = 1'b0; iv2 = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        run("c9999", 16'h9999, 9999, 1'b0);
        run("c0087", 16'h0087, 87, 1'b0);
        run("c12a4", 16'h12A4, 0, 1'b1);
        run("c0000", 16'h0000, 0, 1'b0);
        run("c9000", 16'h9000, 9000, 1'b0);

        issue(16'h0042, lat);
        check("bp_lat", lat, 5);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            bcd_in   = 16'h0033;
            tick();
            check("bp_ov_hold", out_valid, 1);
            check("bp_bin_hold", bin_out, 42);
            check("bp_ir_low", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ov_after_hs", out_valid, 0);
        check("bp_ir_after_hs", in_ready, 1);
        tick();
        check("bp_no_capture", in_ready, 1);

        for (int i = 0; i < 20 && !in_ready; i++) tick();
        bcd_in   = 16'h5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_bin_out", bin_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("midrst_discarded", seen, 0);
        run("c0001", 16'h0001, 1, 1'b0);

        a1 = -1; a2 = -1; h1 = -1; h2 = -1; r1 = '0; r2 = '0;
        out_ready = 1'b1;
        bcd_in    = 16'h0010;
        in_valid  = 1'b1;
        for (int c = 0; c < 40 && h2 < 0; c++) begin
            pr = in_ready;
            pv = out_valid;
            pb = bin_out;
            tick();
            if (pr && in_valid) begin
                if (a1 < 0) begin
                    a1 = c;
                    bcd_in = 16'h0020;
                end else begin
                    a2 = c;
                    in_valid = 1'b0;
                end
            end
            if (pv) begin
                if (h1 < 0) begin
                    h1 = c;
                    r1 = pb;
                end else begin
                    h2 = c;
                    r2 = pb;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_first", r1, 10);
        check("b2b_second", r2, 20);
        check("b2b_accept_after_hs", a2, h1 + 1);

        run2("d2_87", 8'h87, 87, 1'b0);
        run2("d2_99", 8'h99, 99, 1'b0);
        run2("d2_9f", 8'h9F, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin_iter.md
BCD_TO_BIN_ITER -- requirements
Module: bcd_to_bin_iter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst (active-high, synchronous).
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per input word (legal range 1..8).
REQ-003 The block SHALL have parameter BIN_W, default 14, giving the binary output width; the integrator sets BIN_W >= ceil(log2(10^DIGITS)).
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 bcdIn  input  4*DIGITS  packed BCD operand, most significant digit in bits [4*DIGITS-1 : 4*DIGITS-4].
REQ-007 inValid  input  1  bcdIn holds a valid operand.
REQ-008 inReady  output  1  block can accept an operand this cycle.
REQ-009 binOut  output  BIN_W  unsigned binary result.
REQ-010 errOut  output  1  operand contained at least one digit greater than 9; qualified by outValid.
REQ-011 outValid  output  1  binOut and errOut are valid.
REQ-012 outReady  input  1  consumer accepts the result this cycle.

Function
REQ-013 The block SHALL implement three states: IDLE, CONV and DONE.
REQ-014 IDLE: inReady SHALL be 1 and outValid 0; on inValid&&inReady the block SHALL capture bcdIn into a digit shift register, clear acc, digit counter and err flag, and go to CONV.
REQ-015 CONV: each cycle, with d being the top digit of the shift register, the block SHALL set acc <= acc*10 + d (computed as (acc<<3)+(acc<<1)+d, truncated to BIN_W), shift the register left by 4, set err <= err | (d>9) and increment the counter.
REQ-016 CONV: on the cycle the counter equals DIGITS-1, the block SHALL go to DONE after performing that update.
REQ-017 Latency: if an operand is accepted at rising edge k, outValid SHALL first be 1 after edge k+DIGITS+1 (one capture cycle plus DIGITS CONV cycles).
REQ-018 DONE: outValid SHALL be 1, errOut SHALL equal err, and binOut SHALL equal acc when err=0 or 0 when err=1.
REQ-019 DONE: the block SHALL hold binOut, errOut and outValid stable until outValid&&outReady, then go to IDLE on the next edge.
REQ-020 inReady SHALL be 0 in CONV and DONE; inValid in those states SHALL be ignored, with no capture and no state change.
REQ-021 A new operand SHALL NOT be accepted in the same cycle as the output handshake; the earliest new accept is the cycle after the return to IDLE.
REQ-022 An invalid digit SHALL NOT abort the conversion early; the full DIGITS cycles always elapse.
REQ-023 The all-zero operand SHALL produce binOut=0 and errOut=0 with the normal latency.

Reset
REQ-024 While rst=1 at a rising edge, the block SHALL go to IDLE and clear acc, counter, err and shift register, regardless of the current state, including mid-CONV or in DONE with outValid high.
REQ-025 Output values after reset SHALL be inReady=1, outValid=0, binOut=0 and errOut=0; a result in flight SHALL be discarded without a handshake.
REQ-026 The block SHALL ignore inValid during any cycle in which rst=1.

Verification
REQ-027 DIGITS=4, bcdIn=16'h9999 pulsed with outReady=1 -> outValid asserts 5 cycles after the accept edge (DIGITS+1), binOut=9999 (14'h270F), errOut=0.
REQ-028 DIGITS=4, bcdIn=16'h0087 -> binOut=87, errOut=0; DIGITS=2, BIN_W=7, bcdIn=8'h87 -> binOut=7'd87 with outValid 3 cycles (DIGITS+1) after the accept edge.
REQ-029 DIGITS=4, bcdIn=16'h12A4 -> errOut=1, binOut=0, latency unchanged at DIGITS+1 cycles.
REQ-030 Backpressure: result 16'h0042, outReady held 0 for 3 cycles in DONE -> binOut=42 and outValid stable; inValid pulses meanwhile are ignored (inReady=0); outReady=1 -> IDLE next cycle, inReady=1.
REQ-031 Reset mid-CONV: rst asserted on the 2nd CONV cycle of a 16'h5555 conversion -> next cycle state IDLE, outValid=0, binOut=0; a following operand 16'h0001 converts to 1 with errOut=0.
REQ-032 Back-to-back: inValid held high with 16'h0010 then 16'h0020 and outReady=1 -> results 10 then 20 in order, second accept no earlier than the cycle after the first handshake.
